// File: rtl/unary_reduction_sequencer.sv
// rtl/unary_reduction_sequencer.sv - bit-serial unary reduction engine with valid/ready handshakes
// Optional macro UNARY_REDUCTION_SEQUENCER_EARLY_EXIT_EN ends RUN on the first controlling chunk.
module unary_reduction_sequencer #(
  parameter int N = 8,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         c,
  output logic         busy
);

  localparam int CHUNKS = N / W;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] FAM_AND = 2'd0;
  localparam logic [1:0] FAM_OR  = 2'd1;
  localparam logic [1:0] FAM_XOR = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  shreg;
  logic [1:0]    fam;
  logic          inv;
  logic          acc;
  logic [CW-1:0] cnt;
  logic          c_q;

  logic [W-1:0]  chunk;
  logic          acc_next;
  logic          last_fold;
  logic [1:0]    op_fam;

  // 110/111 fall into the AND family, so only 01x and 10x leave it
  always_comb begin
    op_fam = FAM_AND;
    if (op[2:1] == 2'b01) op_fam = FAM_OR;
    if (op[2:1] == 2'b10) op_fam = FAM_XOR;
  end

  always_comb begin
    chunk    = shreg[W-1:0];
    acc_next = acc;
    case (fam)
      FAM_AND: acc_next = acc & (&chunk);
      FAM_OR:  acc_next = acc | (|chunk);
      default: acc_next = acc ^ (^chunk);
    endcase
  end

`ifdef UNARY_REDUCTION_SEQUENCER_EARLY_EXIT_EN
  logic ctrl_hit;
  always_comb begin
    ctrl_hit = 1'b0;
    case (fam)
      FAM_AND: ctrl_hit = ~(&chunk);
      FAM_OR:  ctrl_hit = |chunk;
      default: ctrl_hit = 1'b0;
    endcase
    last_fold = (cnt == LAST) || ctrl_hit;
  end
`else
  always_comb begin
    last_fold = (cnt == LAST);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      fam   <= FAM_AND;
      inv   <= 1'b0;
      acc   <= 1'b0;
      cnt   <= '0;
      c_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= RUN;
            shreg <= a;
            fam   <= op_fam;
            inv   <= op[0];
            cnt   <= '0;
            acc   <= (op_fam == FAM_AND);
          end
        end
        RUN: begin
          acc   <= acc_next;
          shreg <= shreg >> W;
          cnt   <= cnt + 1'b1;
          if (last_fold) begin
            state <= DONE;
            c_q   <= acc_next ^ inv;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign c         = c_q;

endmodule

// File: tb/tb_unary_reduction_sequencer.sv
// tb/tb_unary_reduction_sequencer.sv - directed bench for unary_reduction_sequencer (N=8, W=1 and W=4)
module tb_unary_reduction_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv8 = 1'b0, iv4 = 1'b0;
  logic       ir8, ir4;
  logic [7:0] a8 = '0, a4 = '0;
  logic [2:0] op8 = '0, op4 = '0;
  logic       ov8, ov4;
  logic       or8 = 1'b1, or4 = 1'b1;
  logic       c8, c4;
  logic       b8, b4;

  int checks = 0;
  int errors = 0;

  unary_reduction_sequencer #(.N(8), .W(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .op(op8),
    .out_valid(ov8), .out_ready(or8), .c(c8), .busy(b8)
  );

  unary_reduction_sequencer #(.N(8), .W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .op(op4),
    .out_valid(ov4), .out_ready(or4), .c(c4), .busy(b4)
  );

`ifdef UNARY_REDUCTION_SEQUENCER_EARLY_EXIT_EN
  localparam int LAT_FE = 1;
`else
  localparam int LAT_FE = 8;
`endif

  // Accepts one operand and returns the result and the accept-to-out_valid latency.
  task automatic issue(input bit sel, input logic [7:0] av, input logic [2:0] opv,
                       output logic cv, output int lat);
    @(negedge clk);
    if (sel) begin a4 = av; op4 = opv; iv4 = 1'b1; end
    else begin a8 = av; op8 = opv; iv8 = 1'b1; end
    @(posedge clk);
    #1;
    iv4 = 1'b0;
    iv8 = 1'b0;
    lat = 0;
    cv  = 1'b0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if ((sel ? ov4 : ov8) === 1'b1) break;
    end
    cv = sel ? c4 : c8;
    if ((sel ? or4 : or8) === 1'b1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir8); end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov8); end
    checks++; if (c8 !== 1'b0) begin errors++; $display("FAIL reset_c got %b want 0", c8); end
    checks++; if (b8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", b8); end
    checks++; if (b4 !== 1'b0) begin errors++; $display("FAIL reset_busy_w4 got %b want 0", b4); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_nand;
    logic cv; int lat;
    issue(1'b0, 8'hFF, 3'b001, cv, lat);
    checks++; if (cv !== 1'b0) begin errors++; $display("FAIL nand_ff_c got %b want 0", cv); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL nand_ff_lat got %0d want 8", lat); end
    issue(1'b0, 8'hFE, 3'b001, cv, lat);
    checks++; if (cv !== 1'b1) begin errors++; $display("FAIL nand_fe_c got %b want 1", cv); end
    checks++; if (lat !== LAT_FE) begin errors++; $display("FAIL nand_fe_lat got %0d want %0d", lat, LAT_FE); end
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL nand_idle_in_ready got %b want 1", ir8); end
  endtask

  task automatic test_xor;
    logic cv; int lat;
    issue(1'b0, 8'h07, 3'b100, cv, lat);
    checks++; if (cv !== 1'b1) begin errors++; $display("FAIL xor_07_c got %b want 1", cv); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL xor_07_lat got %0d want 8", lat); end
    issue(1'b0, 8'h07, 3'b101, cv, lat);
    checks++; if (cv !== 1'b0) begin errors++; $display("FAIL xnor_07_c got %b want 0", cv); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL xnor_07_lat got %0d want 8", lat); end
    issue(1'b0, 8'h81, 3'b011, cv, lat);
    checks++; if (cv !== 1'b0) begin errors++; $display("FAIL nor_81_c got %b want 0", cv); end
  endtask

  task automatic test_backpressure;
    logic cv; int lat;
    or8 = 1'b0;
    issue(1'b0, 8'hFF, 3'b000, cv, lat);
    checks++; if (cv !== 1'b1) begin errors++; $display("FAIL bp_and_c got %b want 1", cv); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL bp_and_lat got %0d want 8", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv8 = ~iv8;
      a8  = 8'h00 + 8'(i);
      op8 = 3'b010;
      checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL bp_hold_out_valid cycle %0d got %b want 1", i, ov8); end
      checks++; if (c8 !== 1'b1) begin errors++; $display("FAIL bp_hold_c cycle %0d got %b want 1", i, c8); end
      checks++; if (ir8 !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready cycle %0d got %b want 0", i, ir8); end
    end
    @(negedge clk);
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", ir8); end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", ov8); end
    checks++; if (b8 !== 1'b0) begin errors++; $display("FAIL bp_release_busy got %b want 0", b8); end
  endtask

  task automatic test_reset_mid_run;
    logic cv; int lat;
    @(negedge clk);
    a8 = 8'h80; op8 = 3'b010; iv8 = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (b8 !== 1'b1) begin errors++; $display("FAIL mid_run_busy got %b want 1", b8); end
    rst = 1'b1;
    #1;
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b want 0", ov8); end
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got %b want 1", ir8); end
    checks++; if (b8 !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", b8); end
    @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 8'h00, 3'b010, cv, lat);
    checks++; if (cv !== 1'b0) begin errors++; $display("FAIL post_rst_or_c got %b want 0", cv); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL post_rst_or_lat got %0d want 8", lat); end
  endtask

  task automatic test_w4;
    logic cv; int lat;
    issue(1'b1, 8'h10, 3'b010, cv, lat);
    checks++; if (cv !== 1'b1) begin errors++; $display("FAIL w4_or_c got %b want 1", cv); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL w4_or_lat got %0d want 2", lat); end
    issue(1'b1, 8'hFF, 3'b110, cv, lat);
    checks++; if (cv !== 1'b1) begin errors++; $display("FAIL w4_alias_and_c got %b want 1", cv); end
    issue(1'b1, 8'hEF, 3'b111, cv, lat);
    checks++; if (cv !== 1'b1) begin errors++; $display("FAIL w4_alias_nand_c got %b want 1", cv); end
  endtask

  task automatic test_back_to_back;
    logic cv; int lat;
    issue(1'b1, 8'h3C, 3'b100, cv, lat);
    checks++; if (cv !== 1'b0) begin errors++; $display("FAIL b2b_xor_3c_c got %b want 0", cv); end
    issue(1'b1, 8'h01, 3'b101, cv, lat);
    checks++; if (cv !== 1'b0) begin errors++; $display("FAIL b2b_xnor_01_c got %b want 0", cv); end
    issue(1'b1, 8'h00, 3'b011, cv, lat);
    checks++; if (cv !== 1'b1) begin errors++; $display("FAIL b2b_nor_00_c got %b want 1", cv); end
  endtask

  initial begin
    test_reset();
    test_nand();
    test_xor();
    test_backpressure();
    test_reset_mid_run();
    test_w4();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
